// File: rtl/instruction_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_pkg
//
// Shared definitions for the instruction fetch unit:
//   - fetch_state_t : FSM state encoding (IDLE, FETCH_LO, FETCH_HI, VALID)
//   - IR_LOW/IR_HIGH: values driven on the IR LH select
//   - fetch_ctrl_t  : bundle of the Moore outputs decoded from the state
//   - decode_ctrl() : state -> output-strobe decode, shared so every user
//                     sees exactly the same strobe mapping
// ---------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FETCH_LO = 2'd1,
      FETCH_HI = 2'd2,
      VALID    = 2'd3
   } fetch_state_t;

   // IR half select: the first byte of an instruction lands in IR[7:0].
   localparam logic IR_LOW  = 1'b0;
   localparam logic IR_HIGH = 1'b1;

   typedef struct packed {
      logic mem_read;
      logic ir_write;
      logic ir_lh;
      logic instr_valid;
   } fetch_ctrl_t;

   // Pure function of the registered state, so every strobe is glitch-free
   // with respect to the inputs and has no input-to-output path.
   function automatic fetch_ctrl_t decode_ctrl(input fetch_state_t state);
      fetch_ctrl_t ctrl;
      ctrl = '{mem_read: 1'b0, ir_write: 1'b0, ir_lh: IR_LOW, instr_valid: 1'b0};
      case (state)
         FETCH_LO: begin
            ctrl.mem_read = 1'b1;
            ctrl.ir_write = 1'b1;
            ctrl.ir_lh    = IR_LOW;
         end
         FETCH_HI: begin
            ctrl.mem_read = 1'b1;
            ctrl.ir_write = 1'b1;
            ctrl.ir_lh    = IR_HIGH;
         end
         VALID: begin
            ctrl.instr_valid = 1'b1;
         end
         default: begin
            ctrl.mem_read = 1'b0;
         end
      endcase
      return ctrl;
   endfunction

endpackage : instruction_fetch_unit_pkg

// File: rtl/instruction_fetch_unit_program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
//
// ADDR_WIDTH-bit program counter with synchronous active-high reset to
// RESET_PC, parallel load and increment. Load has priority over increment.
// Increment wraps modulo 2^ADDR_WIDTH with no carry out.
//
// Ports:
//   Clock      in   system clock, updates on posedge
//   Reset      in   synchronous, active-high; Count <= RESET_PC
//   Load       in   Count <= LoadValue
//   Increment  in   Count <= Count + 1 (ignored while Load is high)
//   LoadValue  in   value for Load
//   Count      out  current counter value
// ---------------------------------------------------------------------------
module program_counter #(
   parameter int                    ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Load,
   input  logic                  Increment,
   input  logic [ADDR_WIDTH-1:0] LoadValue,
   output logic [ADDR_WIDTH-1:0] Count
);

   logic [ADDR_WIDTH-1:0] count;

   // NOTE: state registers use non-blocking (<=) so every flop samples the
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         count <= RESET_PC;
      end else if (Load) begin
         count <= LoadValue;
      end else if (Increment) begin
         count <= count + ADDR_WIDTH'(1);
      end
   end

   assign Count = count;

endmodule : program_counter

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Sequences two-byte instruction fetches from byte-wide memory into an
// external InstructionRegister. The first byte (at PC) is written to IR[7:0],
// the second (at PC+1) to IR[15:8]; InstrValid then tells the decoder a full
// 16-bit instruction is held. The decoder acknowledges with Next and may
// redirect the PC with PCLoad while an instruction is held (or while idle).
//
// Parameters:
//   ADDR_WIDTH  width of PC and memory address
//   RESET_PC    PC value after reset
//
// Ports:
//   Clock       in   system clock, all state updates on posedge
//   Reset       in   synchronous, active-high
//   Enable      in   allows a new fetch to start
//   Next        in   decoder consumed the current instruction
//   PCLoad      in   load PC from PCIn (honoured in IDLE and VALID only)
//   PCIn        in   new PC value
//   MemData     in   memory byte; routed to the IR externally, not used here
//   MemAddr     out  memory byte address (= PC)
//   MemRead     out  memory read strobe
//   IRWrite     out  IR write enable
//   IRLH        out  IR half select (0 = IR[7:0], 1 = IR[15:8])
//   InstrValid  out  IR holds a complete instruction
//   PCOut       out  current PC (address of the next byte to fetch)
//
// All outputs are decoded from registered state and PC (Moore machine).
// ---------------------------------------------------------------------------
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Enable,
   input  logic                  Next,
   input  logic                  PCLoad,
   input  logic [ADDR_WIDTH-1:0] PCIn,
   input  logic [7:0]            MemData,
   output logic [ADDR_WIDTH-1:0] MemAddr,
   output logic                  MemRead,
   output logic                  IRWrite,
   output logic                  IRLH,
   output logic                  InstrValid,
   output logic [ADDR_WIDTH-1:0] PCOut
);

   fetch_state_t          state;
   fetch_state_t          state_next;
   logic                  pc_load;
   logic                  pc_inc;
   logic [ADDR_WIDTH-1:0] pc;
   fetch_ctrl_t           ctrl;

   // MemData feeds the IR directly; it is part of this block's bus contract
   // only, so it is deliberately left unconsumed.
   logic unused_memdata;
   assign unused_memdata = ^MemData;

   // -------------------------------------------------------------------------
   // Program counter
   // -------------------------------------------------------------------------
   program_counter #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .RESET_PC   (RESET_PC)
   ) u_program_counter (
      .Clock     (Clock),
      .Reset     (Reset),
      .Load      (pc_load),
      .Increment (pc_inc),
      .LoadValue (PCIn),
      .Count     (pc)
   );

   // -------------------------------------------------------------------------
   // FSM state register
   // -------------------------------------------------------------------------
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // -------------------------------------------------------------------------
   // FSM next-state and PC control
   // -------------------------------------------------------------------------
   // NOTE: every signal assigned in this block gets a default first, so no
   // path through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      pc_load    = 1'b0;
      pc_inc     = 1'b0;

      case (state)
         IDLE: begin
            // A jump while idle is taken immediately; if Enable is also
            // high the fetch starts from the new PC on the following cycle.
            pc_load = PCLoad;
            if (Enable) begin
               state_next = FETCH_LO;
            end
         end

         FETCH_LO: begin
            // PCLoad is ignored mid-fetch; Enable dropping does not abort.
            pc_inc     = 1'b1;
            state_next = FETCH_HI;
         end

         FETCH_HI: begin
            pc_inc     = 1'b1;
            state_next = VALID;
         end

         VALID: begin
            pc_load = PCLoad;
            if (Next) begin
               state_next = Enable ? FETCH_LO : IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Output decode (registered state / PC only)
   // -------------------------------------------------------------------------
   assign ctrl       = decode_ctrl(state);
   assign MemRead    = ctrl.mem_read;
   assign IRWrite    = ctrl.ir_write;
   assign IRLH       = ctrl.ir_lh;
   assign InstrValid = ctrl.instr_valid;
   assign MemAddr    = pc;
   assign PCOut      = pc;

endmodule : instruction_fetch_unit

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Two DUT instances share every input: dut0 with RESET_PC = 0 and dut1 with
// RESET_PC = 0xFFFE (address wrap). 'sel' picks which instance the monitor
// observes. Stimulus pushes expected fetch cycles (address, half) and
// expected completed instructions (IR value, PC) into queues; the monitor
// pops and compares whenever the observed DUT strobes MemRead or raises
// InstrValid. A behavioural IR captures MemData on IRWrite.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

   typedef struct {
      logic [15:0] addr;
      logic        lh;
   } fetch_exp_t;

   typedef struct {
      logic [15:0] ir;
      logic [15:0] pc;
   } instr_exp_t;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Enable;
   logic        Next;
   logic        PCLoad;
   logic [15:0] PCIn;

   logic [15:0] mem_addr0, mem_addr1, pc_out0, pc_out1;
   logic [7:0]  mem_data0, mem_data1;
   logic        mem_read0, mem_read1, ir_write0, ir_write1;
   logic        ir_lh0, ir_lh1, instr_valid0, instr_valid1;

   logic        sel;
   logic [15:0] mon_addr, mon_pc;
   logic [7:0]  mon_data;
   logic        mon_read, mon_write, mon_lh, mon_valid;

   logic [7:0]  mem [0:65535];
   logic [15:0] ir_model;
   logic        prev_valid;

   fetch_exp_t  exp_fetch_q[$];
   instr_exp_t  exp_instr_q[$];

   int vectors     = 0;
   int miscompares = 0;

   always #5 Clock = ~Clock;

   assign mem_data0 = mem[mem_addr0];
   assign mem_data1 = mem[mem_addr1];

   instruction_fetch_unit #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut0 (
      .Clock (Clock), .Reset (Reset), .Enable (Enable), .Next (Next),
      .PCLoad (PCLoad), .PCIn (PCIn), .MemData (mem_data0),
      .MemAddr (mem_addr0), .MemRead (mem_read0), .IRWrite (ir_write0),
      .IRLH (ir_lh0), .InstrValid (instr_valid0), .PCOut (pc_out0)
   );

   instruction_fetch_unit #(.ADDR_WIDTH(16), .RESET_PC(16'hFFFE)) dut1 (
      .Clock (Clock), .Reset (Reset), .Enable (Enable), .Next (Next),
      .PCLoad (PCLoad), .PCIn (PCIn), .MemData (mem_data1),
      .MemAddr (mem_addr1), .MemRead (mem_read1), .IRWrite (ir_write1),
      .IRLH (ir_lh1), .InstrValid (instr_valid1), .PCOut (pc_out1)
   );

   assign mon_addr  = sel ? mem_addr1    : mem_addr0;
   assign mon_pc    = sel ? pc_out1      : pc_out0;
   assign mon_data  = sel ? mem_data1    : mem_data0;
   assign mon_read  = sel ? mem_read1    : mem_read0;
   assign mon_write = sel ? ir_write1    : ir_write0;
   assign mon_lh    = sel ? ir_lh1       : ir_lh0;
   assign mon_valid = sel ? instr_valid1 : instr_valid0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural InstructionRegister.
   always @(posedge Clock) begin
      if (mon_write === 1'b1) begin
         if (mon_lh) ir_model[15:8] <= mon_data;
         else        ir_model[7:0]  <= mon_data;
      end
   end

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge Clock) begin
      if (mon_read === 1'b1) begin
         check("fetch_expected", 32'(exp_fetch_q.size() != 0), 32'd1);
         if (exp_fetch_q.size() != 0) begin
            fetch_exp_t e;
            e = exp_fetch_q.pop_front();
            check("fetch_addr", 32'(mon_addr), 32'(e.addr));
            check("fetch_irlh", 32'(mon_lh), 32'(e.lh));
            check("fetch_irwrite", 32'(mon_write), 32'd1);
         end
      end
      if (mon_valid === 1'b1 && prev_valid !== 1'b1) begin
         check("instr_expected", 32'(exp_instr_q.size() != 0), 32'd1);
         if (exp_instr_q.size() != 0) begin
            instr_exp_t e;
            e = exp_instr_q.pop_front();
            check("instr_ir", 32'(ir_model), 32'(e.ir));
            check("instr_pcout", 32'(mon_pc), 32'(e.pc));
         end
      end
      prev_valid <= mon_valid;
   end

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic push_fetch(input logic [15:0] addr, input logic lh);
      fetch_exp_t e;
      e.addr = addr;
      e.lh   = lh;
      exp_fetch_q.push_back(e);
   endtask

   task automatic push_instr(input logic [15:0] ir, input logic [15:0] pc);
      instr_exp_t e;
      e.ir = ir;
      e.pc = pc;
      exp_instr_q.push_back(e);
   endtask

   // Steps until InstrValid is seen, bounded; returns the number of edges.
   task automatic wait_valid(output int cycles);
      cycles = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         cycles++;
         if (mon_valid === 1'b1) break;
      end
      check("valid_within_budget", 32'(mon_valid), 32'd1);
   endtask

   task automatic check_idle_outputs(input string tag, input logic [15:0] pc);
      check({tag, "_memread"},    32'(mon_read),  32'd0);
      check({tag, "_irwrite"},    32'(mon_write), 32'd0);
      check({tag, "_irlh"},       32'(mon_lh),    32'd0);
      check({tag, "_instrvalid"}, 32'(mon_valid), 32'd0);
      check({tag, "_memaddr"},    32'(mon_addr),  32'(pc));
      check({tag, "_pcout"},      32'(mon_pc),    32'(pc));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cycles;

      for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
      mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h12;
      mem[16'h0002] = 8'h78; mem[16'h0003] = 8'h56;
      mem[16'h0004] = 8'hBC; mem[16'h0005] = 8'h9A;
      mem[16'h0006] = 8'hF0; mem[16'h0007] = 8'hDE;
      mem[16'h0020] = 8'h77; mem[16'h0021] = 8'h88;
      mem[16'h0100] = 8'hCD; mem[16'h0101] = 8'hAB;
      mem[16'h0200] = 8'h55; mem[16'h0201] = 8'h66;
      mem[16'hFFFE] = 8'hEF; mem[16'hFFFF] = 8'hBE;

      sel    = 1'b0;
      Reset  = 1'b1;
      Enable = 1'b0;
      Next   = 1'b0;
      PCLoad = 1'b0;
      PCIn   = 16'h0000;
      step();
      step();
      check_idle_outputs("reset", 16'h0000);
      Reset = 1'b0;
      step();
      check_idle_outputs("idle_hold", 16'h0000);

      // First instruction: 0x34, 0x12 -> IR 0x1234, valid 3 edges later.
      push_fetch(16'h0000, 1'b0);
      push_fetch(16'h0001, 1'b1);
      push_instr(16'h1234, 16'h0002);
      Enable = 1'b1;
      wait_valid(cycles);
      check("first_latency", 32'(cycles), 32'd3);

      // Back-to-back with Next held: InstrValid pattern 0,0,1 per instruction.
      push_fetch(16'h0002, 1'b0); push_fetch(16'h0003, 1'b1);
      push_fetch(16'h0004, 1'b0); push_fetch(16'h0005, 1'b1);
      push_fetch(16'h0006, 1'b0); push_fetch(16'h0007, 1'b1);
      push_instr(16'h5678, 16'h0004);
      push_instr(16'h9ABC, 16'h0006);
      push_instr(16'hDEF0, 16'h0008);
      Next = 1'b1;
      for (int i = 0; i < 9; i++) begin
         step();
         check("valid_pattern", 32'(mon_valid), 32'((i % 3) == 2));
      end
      Next = 1'b0;

      // Jump with Next: fetch from 0x0100; PCLoad held mid-fetch is ignored.
      push_fetch(16'h0100, 1'b0);
      push_fetch(16'h0101, 1'b1);
      push_instr(16'hABCD, 16'h0102);
      PCLoad = 1'b1;
      PCIn   = 16'h0100;
      Next   = 1'b1;
      step();
      Next = 1'b0;
      PCIn = 16'h3333;
      step();
      step();
      PCLoad = 1'b0;
      check("jump_reached_valid", 32'(mon_valid), 32'd1);

      // PCLoad without Next: stays VALID, PC takes the new value.
      PCLoad = 1'b1;
      PCIn   = 16'h0200;
      step();
      PCLoad = 1'b0;
      check("load_no_next_valid", 32'(mon_valid), 32'd1);
      check("load_no_next_pc", 32'(mon_pc), 32'h0200);

      // Enable dropped during FETCH_LO: fetch still completes.
      push_fetch(16'h0200, 1'b0);
      push_fetch(16'h0201, 1'b1);
      push_instr(16'h6655, 16'h0202);
      Next = 1'b1;
      step();
      Next   = 1'b0;
      Enable = 1'b0;
      wait_valid(cycles);
      check("enable_drop_latency", 32'(cycles), 32'd2);

      // Next with Enable low -> IDLE, no further reads (monitor flags any).
      Next = 1'b1;
      step();
      Next = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check_idle_outputs("next_to_idle", 16'h0202);

      // PCLoad in IDLE, then PCLoad together with Enable.
      PCLoad = 1'b1;
      PCIn   = 16'h0010;
      step();
      check_idle_outputs("idle_load", 16'h0010);
      push_fetch(16'h0020, 1'b0);
      push_fetch(16'h0021, 1'b1);
      push_instr(16'h8877, 16'h0022);
      PCIn   = 16'h0020;
      Enable = 1'b1;
      step();
      PCLoad = 1'b0;
      Enable = 1'b0;
      wait_valid(cycles);
      check("idle_load_enable_latency", 32'(cycles), 32'd2);

      // Reset during FETCH_HI aborts the fetch.
      push_fetch(16'h0022, 1'b0);
      push_fetch(16'h0023, 1'b1);
      Next   = 1'b1;
      Enable = 1'b1;
      step();
      Next   = 1'b0;
      Enable = 1'b0;
      step();
      check("in_fetch_hi", 32'(mon_lh), 32'd1);
      Reset = 1'b1;
      step();
      check_idle_outputs("reset_mid_fetch", 16'h0000);
      Reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("post_reset_not_valid", 32'(mon_valid), 32'd0);
      end

      // Address wrap on the RESET_PC = 0xFFFE instance.
      Reset = 1'b1;
      step();
      sel = 1'b1;
      step();
      check_idle_outputs("wrap_reset", 16'hFFFE);
      Reset = 1'b0;
      push_fetch(16'hFFFE, 1'b0);
      push_fetch(16'hFFFF, 1'b1);
      push_fetch(16'h0000, 1'b0);
      push_fetch(16'h0001, 1'b1);
      push_instr(16'hBEEF, 16'h0000);
      push_instr(16'h1234, 16'h0002);
      Enable = 1'b1;
      wait_valid(cycles);
      check("wrap_first_latency", 32'(cycles), 32'd3);
      Next = 1'b1;
      step();
      Next = 1'b0;
      wait_valid(cycles);
      check("wrap_second_latency", 32'(cycles), 32'd2);
      Enable = 1'b0;
      Next   = 1'b1;
      step();
      Next = 1'b0;
      step();
      step();

      check("fetch_queue_drained", 32'(exp_fetch_q.size()), 32'd0);
      check("instr_queue_drained", 32'(exp_instr_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_instruction_fetch_unit

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Sequences two-byte instruction fetches from byte-wide memory into the InstructionRegister. Owns the program counter, drives the memory address/read strobe and the IR's Write/LH controls, and signals the downstream decoder when a complete 16-bit instruction is held in the IR. Accepts PC loads (jumps/branches) from the decoder between instructions.

## Interface
Parameters:
- ADDR_WIDTH, 16, width of PC and memory address
- RESET_PC, 0, PC value after reset

Ports:
- Clock  in  1  system clock, all state updates on posedge
- Reset  in  1  synchronous, active-high; clears the block on the next posedge
- Enable  in  1  allows a new fetch to start
- Next  in  1  decoder has consumed the current instruction; request next
- PCLoad  in  1  load PC from PCIn (jump/branch)
- PCIn  in  ADDR_WIDTH  new PC value for PCLoad
- MemData  in  8  byte read from memory (combinational read, valid same cycle as MemAddr)
- MemAddr  out  ADDR_WIDTH  memory byte address, equals PC
- MemRead  out  1  memory read strobe
- IRWrite  out  1  connects to IR Write
- IRLH  out  1  connects to IR LH (0 = IR[7:0], 1 = IR[15:8])
- InstrValid  out  1  IR holds a complete instruction
- PCOut  out  ADDR_WIDTH  current PC (address of next byte to fetch)

MemData passes through the IR data path externally; this block only observes it for no purpose other than the bus contract (no internal use).

## Operation
- States: IDLE, FETCH_LO, FETCH_HI, VALID.
- IDLE: all strobes low. Enable=1 -> FETCH_LO. PCLoad=1 loads PC (stays IDLE unless Enable also 1, then FETCH_LO from new PC).
- FETCH_LO: MemRead=1, IRWrite=1, IRLH=0; PC <= PC+1; -> FETCH_HI. Byte at even-order position (first byte) lands in IR[7:0].
- FETCH_HI: MemRead=1, IRWrite=1, IRLH=1; PC <= PC+1; -> VALID.
- VALID: InstrValid=1, strobes low. Waits for Next.
  - Next=1, Enable=1 -> FETCH_LO.
  - Next=1, Enable=0 -> IDLE.
  - PCLoad=1 (with or without Next): PC <= PCIn; PCLoad wins over increment. Next/Enable decide the successor state as above; PCLoad without Next stays VALID.
- PCLoad in FETCH_LO/FETCH_HI is ignored (decoder only issues it while InstrValid=1).
- Enable falling mid-fetch: current fetch completes to VALID.
- Arithmetic: PC increment modulo 2^ADDR_WIDTH; PC = all-ones increments to 0, no flag.
- All outputs are decoded from registered state/PC (Moore); no input-to-output combinational path.

## Timing
- Reset values: state IDLE, PC = RESET_PC, MemAddr = PCOut = RESET_PC, MemRead = IRWrite = IRLH = InstrValid = 0.
- Reset asserted in any state aborts the fetch at the next posedge; any partial IR contents are not flagged valid.
- Latency: Enable high in IDLE at edge N -> FETCH_LO during cycle N+1, FETCH_HI N+2, InstrValid=1 from N+3.
- Back-to-back: Next at VALID edge -> InstrValid low for exactly 2 cycles, then high again; throughput one instruction per 3 cycles.
- IR captures on the same edge that leaves FETCH_LO/FETCH_HI; MemAddr stable for the entire fetch cycle.
- InstrValid drops the cycle after Next is sampled.

## Structure
- Shared package: state encoding localparams (IDLE=2'd0, FETCH_LO=2'd1, FETCH_HI=2'd2, VALID=2'd3), IR_LOW=1'b0, IR_HIGH=1'b1.
- One sub-module: program_counter (ADDR_WIDTH register with synchronous reset to RESET_PC, load, increment; load priority over increment).
- Top holds the FSM and output decode.

## Test plan
- Reset then Enable=1, memory [0x0000]=0x34, [0x0001]=0x12 -> IRLH 0 then 1 on consecutive cycles, IR = 0x1234, InstrValid high 3 cycles after Enable, PCOut = 0x0002.
- Hold Next=1, Enable=1 over 4 instructions -> InstrValid pattern 1,0,0 repeating; MemAddr 0,1,2,3,...,7; PCOut = 0x0008.
- In VALID assert PCLoad=1, PCIn=0x0100, Next=1 -> next fetch reads 0x0100/0x0101, PCOut = 0x0102 after.
- RESET_PC=0xFFFE: fetch two instructions -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; no stall at wrap.
- Reset asserted during FETCH_HI -> next cycle IDLE, all strobes 0, PCOut = RESET_PC, InstrValid stays 0.
- Enable dropped during FETCH_LO -> fetch still reaches VALID; Next with Enable=0 -> IDLE, no further MemRead.
